// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants and the writeback entry type
package cpu_pkg;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int NREG = 4;

  typedef struct packed {
    logic [AW-1:0] dr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO of writeback entries
// Pointers carry one extra bit so full and empty are distinguishable.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic [PW:0] count,
  output logic      full,
  output logic      empty
);

  logic [PW:0] wr_ptr_q, rd_ptr_q;
  wb_entry_t   mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[PW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file write-port driver with result FIFO and pending-write scoreboard
// Memory results take fixed priority over ALU results; one write issues per cycle unless held.
module reg_writeback #(
  parameter int DW    = cpu_pkg::DW,
  parameter int AW    = cpu_pkg::AW,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [AW-1:0]     mem_dr,
  input  logic [DW-1:0]     mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_dr,
  input  logic [DW-1:0]     alu_data,
  input  logic              hold,
  input  logic              claim_valid,
  input  logic [AW-1:0]     claim_dr,
  output logic              rf_we,
  output logic [AW-1:0]     rf_dr,
  output logic [DW-1:0]     rf_i,
  output logic [2**AW-1:0]  busy,
  output logic [AW-1:0]     count,
  output logic              err
);

  localparam int NREG = 2**AW;
  localparam int PW   = $clog2(DEPTH);

  cpu_pkg::wb_entry_t push_entry, head;
  logic          push, pop, full, empty;
  logic [PW:0]   fifo_count;

  logic          rf_we_q;
  logic [AW-1:0] rf_dr_q;
  logic [DW-1:0] rf_i_q;

  logic [1:0]      cnt_q [NREG];
  logic [1:0]      cnt_d [NREG];
  logic            err_q, err_d;
  logic [NREG-1:0] claim_hit, done_hit;

  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign pop       = !empty && !hold;

  always_comb begin
    push_entry.dr   = alu_dr;
    push_entry.data = alu_data;
    if (mem_valid) begin
      push_entry.dr   = mem_dr;
      push_entry.data = mem_data;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_dr_q <= '0;
      rf_i_q  <= '0;
    end else begin
      rf_we_q <= pop;
      if (pop) begin
        rf_dr_q <= head.dr;
        rf_i_q  <= head.data;
      end
    end
  end

  // A write retires at the edge that ends its rf_we cycle.
  always_comb begin
    claim_hit = '0;
    done_hit  = '0;
    if (claim_valid) claim_hit[claim_dr] = 1'b1;
    if (rf_we_q)     done_hit[rf_dr_q]   = 1'b1;
  end

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      busy[r]  = (cnt_q[r] != 2'd0);
      if (claim_hit[r] && !done_hit[r]) begin
        if (cnt_q[r] == 2'd3) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (done_hit[r] && !claim_hit[r]) begin
        if (cnt_q[r] == 2'd0) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
    end else begin
      err_q <= err_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign rf_we = rf_we_q;
  assign rf_dr = rf_dr_q;
  assign rf_i  = rf_i_q;
  assign err   = err_q;
  assign count = AW'(fifo_count);

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - randomized scoreboard bench for reg_writeback
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic       clk, rst;
  logic       mem_valid, mem_ready, alu_valid, alu_ready;
  logic [1:0] mem_dr, alu_dr, claim_dr, rf_dr, count;
  logic [7:0] mem_data, alu_data, rf_i;
  logic       hold, claim_valid, rf_we, err;
  logic [3:0] busy;

  reg_writeback #(.DW(8), .AW(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dr(mem_dr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dr(alu_dr), .alu_data(alu_data),
    .hold(hold), .claim_valid(claim_valid), .claim_dr(claim_dr),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_i(rf_i), .busy(busy), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued writes in acceptance order, per-register outstanding claims.
  logic [9:0] exp_q[$];
  int         cnt_m [4];
  bit         err_m;
  bit         exp_we_next;
  bit         cur_we;
  logic [1:0] cur_dr;
  bit         mon_en;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int busy_m();
    int b = 0;
    for (int r = 0; r < 4; r++) if (cnt_m[r] != 0) b |= (1 << r);
    return b;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [9:0] e;
      chk("rf_we", int'(rf_we), int'(exp_we_next));
      cur_we = 1'b0;
      if (exp_we_next) begin
        if (exp_q.size() == 0) begin
          chk("write_queue_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("rf_dr", int'(rf_dr), int'(e[9:8]));
          chk("rf_i", int'(rf_i), int'(e[7:0]));
          cur_we = 1'b1;
          cur_dr = e[9:8];
        end
      end
      chk("count", int'(count), exp_q.size());
      chk("busy", int'(busy), busy_m());
      chk("err", int'(err), int'(err_m));
    end
  end

  // One cycle of stimulus, applied just after a negedge; returns model-predicted acceptance.
  task automatic cyc(input bit mv, input logic [1:0] mdr, input logic [7:0] md,
                     input bit av, input logic [1:0] adr, input logic [7:0] ad,
                     input bit h, input bit cv, input logic [1:0] cdr,
                     output bit macc, output bit aacc);
    bit room;
    mem_valid = mv; mem_dr = mdr; mem_data = md;
    alu_valid = av; alu_dr = adr; alu_data = ad;
    hold = h; claim_valid = cv; claim_dr = cdr;
    #4;
    room = (exp_q.size() < DEPTH);
    chk("mem_ready", int'(mem_ready), int'(room));
    chk("alu_ready", int'(alu_ready), int'(room && !mv));
    macc = mv && room;
    aacc = av && !mv && room;
    exp_we_next = (exp_q.size() > 0) && !h;
    if (macc)      exp_q.push_back({mdr, md});
    else if (aacc) exp_q.push_back({adr, ad});
    for (int r = 0; r < 4; r++) begin
      int n = cnt_m[r];
      if (cv && cdr == 2'(r))        n++;
      if (cur_we && cur_dr == 2'(r)) n--;
      if (n > 3) begin n = 3; err_m = 1'b1; end
      if (n < 0) begin n = 0; err_m = 1'b1; end
      cnt_m[r] = n;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic claim(input logic [1:0] r);
    bit a, b;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, r, a, b);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    mem_valid = 0; alu_valid = 0; claim_valid = 0; hold = 0;
    #2 rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_rf_we", int'(rf_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    exp_q.delete();
    for (int r = 0; r < 4; r++) cnt_m[r] = 0;
    err_m = 0; exp_we_next = 0; cur_we = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    bit         a, b, mp, ap, cv, h;
    logic [1:0] mdr_r, adr_r, cdr;
    logic [7:0] md_r, ad_r;
    logic [1:0] claimed[$];
    int         n;

    rst = 1'b1; mon_en = 1'b0; err_m = 0; exp_we_next = 0; cur_we = 0; cur_dr = 0;
    for (int r = 0; r < 4; r++) cnt_m[r] = 0;
    mem_valid = 0; mem_dr = 0; mem_data = 0; alu_valid = 0; alu_dr = 0; alu_data = 0;
    hold = 0; claim_valid = 0; claim_dr = 0;
    repeat (3) @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_rf_we", int'(rf_we), 0);
    chk("reset_rf_dr", int'(rf_dr), 0);
    chk("reset_rf_i", int'(rf_i), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single write
    claim(2);
    cyc(0, 0, 0, 1, 2, 8'h5A, 0, 0, 0, a, b);
    idle(3);

    // Priority: memory wins, ALU follows next cycle
    claim(1);
    claim(3);
    cyc(1, 1, 8'h11, 1, 3, 8'h33, 0, 0, 0, a, b);
    chk("prio_alu_blocked", int'(b), 0);
    cyc(0, 0, 0, 1, 3, 8'h33, 0, 0, 0, a, b);
    idle(3);

    // Full under hold, then push+pop once a slot frees
    claim(0); claim(3); claim(2);
    cyc(1, 0, 8'hA0, 0, 0, 0, 1, 0, 0, a, b);
    cyc(0, 0, 0, 1, 3, 8'hB3, 1, 0, 0, a, b);
    cyc(1, 2, 8'hC2, 0, 0, 0, 1, 0, 0, a, b);
    cyc(1, 2, 8'hC2, 0, 0, 0, 0, 0, 0, a, b);
    cyc(1, 2, 8'hC2, 0, 0, 0, 0, 0, 0, a, b);
    idle(4);

    // Randomized traffic; every write is claimed before its producer offers it
    mp = 0; ap = 0; mdr_r = 0; adr_r = 0; md_r = 0; ad_r = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mp && claimed.size() > 0 && $urandom_range(0, 1) == 1) begin
        mp = 1; mdr_r = claimed.pop_front(); md_r = 8'($urandom);
      end
      if (!ap && claimed.size() > 0 && $urandom_range(0, 1) == 1) begin
        ap = 1; adr_r = claimed.pop_front(); ad_r = 8'($urandom);
      end
      cdr = 2'($urandom_range(0, 3));
      cv  = ($urandom_range(0, 2) == 0) && (cnt_m[cdr] < 3);
      if (cv) claimed.push_back(cdr);
      h = ($urandom_range(0, 3) == 0);
      cyc(mp, mdr_r, md_r, ap, adr_r, ad_r, h, cv, cdr, a, b);
      if (a) mp = 0;
      if (b) ap = 0;
    end
    n = 0;
    while ((mp || ap || claimed.size() > 0) && n < 60) begin
      if (!mp && claimed.size() > 0) begin mp = 1; mdr_r = claimed.pop_front(); md_r = 8'($urandom); end
      cyc(mp, mdr_r, md_r, ap, adr_r, ad_r, 0, 0, 0, a, b);
      if (a) mp = 0;
      if (b) ap = 0;
      n++;
    end
    chk("random_drained", int'(mp || ap || claimed.size() > 0), 0);
    idle(4);

    // Reset mid-operation with two writes queued and r1/r2 busy
    claim(1); claim(2);
    cyc(1, 1, 8'h77, 0, 0, 0, 1, 0, 0, a, b);
    cyc(0, 0, 0, 1, 2, 8'h88, 1, 0, 0, a, b);
    chk("pre_rst_busy", int'(busy), 4'b0110);
    async_reset();
    idle(4);

    // Four claims of r0: saturates at 3 and flags on the fourth
    claim(0); claim(0); claim(0);
    chk("claims3_err", int'(err), 0);
    claim(0);
    idle(1);
    chk("sat_err", int'(err), 1);
    async_reset();

    // Unclaimed write to r1
    cyc(0, 0, 0, 1, 1, 8'h5C, 0, 0, 0, a, b);
    idle(3);
    chk("unclaimed_err", int'(err), 1);
    chk("unclaimed_busy1", int'(busy[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
